cla_carry_pipe: RTL and testbench

Pipelined carry-lookahead unit for the 64-bit CLA datapath. It consumes the per-bit propagate/generate vectors produced by the partial-full-adder stage, plus a carry-in. It returns the carry into every bit position, which the PFA row XORs with P to form the sum. It uses a three-stage lookahead tree (4-bit groups, then 16-bit blocks, then bit carries) with a valid/ready handshake at both ends, giving throughput of one operand per cycle.

---
 rtl/cla_pkg.sv | 20 ++
 rtl/cla_lookahead4.sv | 18 +
 rtl/cla_carry_pipe.sv | 164 ++++++++++++++++
 tb/tb_cla_carry_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, propagate/generate pair type and combine operator
// for the pipelined carry-lookahead unit.
package cla_pkg;

    localparam int GRP_W      = 4;
    localparam int BLK_W      = 16;
    localparam int PIPE_DEPTH = 3;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Prefix operator: hi spans the more significant bits, lo the less significant.
    function automatic pg_t pg_combine(pg_t hi, pg_t lo);
        pg_combine.p = hi.p & lo.p;
        pg_combine.g = hi.g | (hi.p & lo.g);
    endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// cla_lookahead4: four-wide lookahead cell producing internal carries and the
// combined group propagate/generate; used for bits within a group and for groups within a block.
module cla_lookahead4
    import cla_pkg::*;
(
    input  pg_t  [3:0] pg,
    input  logic       ci,
    output logic [3:1] c,
    output pg_t        grp
);

    assign c[1] = pg[0].g | (pg[0].p & ci);
    assign c[2] = pg[1].g | (pg[1].p & pg[0].g) | (pg[1].p & pg[0].p & ci);
    assign c[3] = pg[2].g | (pg[2].p & pg[1].g) | (pg[2].p & pg[1].p & pg[0].g)
                | (pg[2].p & pg[1].p & pg[0].p & ci);
    assign grp  = pg_combine(pg_combine(pg[3], pg[2]), pg_combine(pg[1], pg[0]));

endmodule

// File: rtl/cla_carry_pipe.sv
// cla_carry_pipe: three-stage carry-lookahead tree (groups, blocks, bit carries) with
// valid/ready at both ends. Define CLA_OVERFLOW_EN to add the registered V output.
module cla_carry_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] G,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] C,
    output logic             COUT,
    output logic             GP,
`ifdef CLA_OVERFLOW_EN
    output logic             GG,
    output logic             V
`else
    output logic             GG
`endif
);

    localparam int NG  = WIDTH / GRP_W;
    localparam int NB  = WIDTH / BLK_W;
    localparam int GPB = BLK_W / GRP_W;

    logic [PIPE_DEPTH-1:0] vld;
    logic [PIPE_DEPTH-1:0] ld;

    pg_t  [WIDTH-1:0] bit_in;
    pg_t  [NG-1:0]    grp_nx;
    pg_t  [WIDTH-1:0] bits1;
    pg_t  [NG-1:0]    grp1;
    logic             cin1;

    pg_t  [NB-1:0]    blk_nx;
    logic [NB-1:0]    bc_nx;
    pg_t  [WIDTH-1:0] bits2;
    pg_t  [NG-1:0]    grp2;
    pg_t  [NB-1:0]    blk2;
    logic [NB-1:0]    bc2;

    logic [NB-1:0][3:1] blk_c;
    pg_t  [NB-1:0]      blk_unused;
    logic [NG-1:0]      gc;
    logic [NG-1:0][3:1] grp_c;
    pg_t  [NG-1:0]      grp_unused;
    logic [WIDTH-1:0]   c_nx;
    pg_t                word;
    logic               cout_nx;

    logic [WIDTH-1:0] c3;
    logic             cout3;
    logic             gp3;
    logic             gg3;

    // Each stage advances when empty or when the stage after it advances.
    assign ld[2]     = !vld[2] || OUT_READY;
    assign ld[1]     = !vld[1] || ld[2];
    assign ld[0]     = !vld[0] || ld[1];
    assign IN_READY  = ld[0];
    assign OUT_VALID = vld[2];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) bit_in[i] = '{p: P[i], g: G[i]};
        for (int k = 0; k < NG; k++)
            grp_nx[k] = pg_combine(pg_combine(bit_in[GRP_W*k+3], bit_in[GRP_W*k+2]),
                                   pg_combine(bit_in[GRP_W*k+1], bit_in[GRP_W*k]));
    end

    always_comb begin
        for (int j = 0; j < NB; j++)
            blk_nx[j] = pg_combine(pg_combine(grp1[GPB*j+3], grp1[GPB*j+2]),
                                   pg_combine(grp1[GPB*j+1], grp1[GPB*j]));
        bc_nx[0] = cin1;
        for (int j = 1; j < NB; j++) bc_nx[j] = blk_nx[j-1].g | (blk_nx[j-1].p & bc_nx[j-1]);
    end

    genvar j, k;
    generate
        for (j = 0; j < NB; j++) begin : g_blk
            cla_lookahead4 u_blk (
                .pg  (grp2[GPB*j +: GPB]),
                .ci  (bc2[j]),
                .c   (blk_c[j]),
                .grp (blk_unused[j])
            );
            assign gc[GPB*j +: GPB] = {blk_c[j], bc2[j]};
        end
        for (k = 0; k < NG; k++) begin : g_grp
            cla_lookahead4 u_grp (
                .pg  (bits2[GRP_W*k +: GRP_W]),
                .ci  (gc[k]),
                .c   (grp_c[k]),
                .grp (grp_unused[k])
            );
            assign c_nx[GRP_W*k +: GRP_W] = {grp_c[k], gc[k]};
        end
    endgenerate

    // Whole-word p/g: its generate term is the carry out with a zero carry-in.
    always_comb begin
        word = blk2[0];
        for (int b = 1; b < NB; b++) word = pg_combine(blk2[b], word);
        cout_nx = blk2[NB-1].g | (blk2[NB-1].p & bc2[NB-1]);
    end

`ifdef CLA_OVERFLOW_EN
    logic v3;
    assign V = v3;
    always_ff @(posedge CLK or posedge RST)
        if (RST) v3 <= 1'b0;
        else if (ld[2] && vld[1]) v3 <= c_nx[WIDTH-1] ^ cout_nx;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld   <= '0;
            bits1 <= '0;
            grp1  <= '0;
            cin1  <= 1'b0;
            bits2 <= '0;
            grp2  <= '0;
            blk2  <= '0;
            bc2   <= '0;
            c3    <= '0;
            cout3 <= 1'b0;
            gp3   <= 1'b0;
            gg3   <= 1'b0;
        end else begin
            if (ld[0]) vld[0] <= IN_VALID;
            if (ld[1]) vld[1] <= vld[0];
            if (ld[2]) vld[2] <= vld[1];
            if (ld[0] && IN_VALID) begin
                bits1 <= bit_in;
                grp1  <= grp_nx;
                cin1  <= CIN;
            end
            if (ld[1] && vld[0]) begin
                bits2 <= bits1;
                grp2  <= grp1;
                blk2  <= blk_nx;
                bc2   <= bc_nx;
            end
            if (ld[2] && vld[1]) begin
                c3    <= c_nx;
                cout3 <= cout_nx;
                gp3   <= word.p;
                gg3   <= word.g;
            end
        end
    end

    assign C    = c3;
    assign COUT = cout3;
    assign GP   = gp3;
    assign GG   = gg3;

endmodule

// File: tb/tb_cla_carry_pipe.sv
// tb_cla_carry_pipe: directed and random checks of cla_carry_pipe against a
// bit-serial ripple-carry reference, at WIDTH=64 and WIDTH=16.
module tb_cla_carry_pipe;

    typedef struct {
        logic [63:0] c;
        logic        cout;
        logic        gp;
        logic        gg;
        logic        v;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY, CIN, COUT, GP, GG;
    logic [63:0] P, G, C;
    logic        iv16, ir16, ov16, cin16, cout16, gp16, gg16;
    logic [15:0] p16, g16, c16;
`ifdef CLA_OVERFLOW_EN
    logic        V, v16;
`endif

    exp_t q[$];
    int   pass_cnt = 0;
    int   total    = 0;

    always #5 CLK = ~CLK;

    cla_carry_pipe #(.WIDTH(64)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .P(P), .G(G), .CIN(CIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
`ifdef CLA_OVERFLOW_EN
        .V(V),
`endif
        .C(C), .COUT(COUT), .GP(GP), .GG(GG)
    );

    cla_carry_pipe #(.WIDTH(16)) dut16 (
        .CLK(CLK), .RST(RST), .IN_VALID(iv16), .IN_READY(ir16),
        .P(p16), .G(g16), .CIN(cin16), .OUT_VALID(ov16), .OUT_READY(1'b1),
`ifdef CLA_OVERFLOW_EN
        .V(v16),
`endif
        .C(c16), .COUT(cout16), .GP(gp16), .GG(gg16)
    );

    function automatic exp_t ref_model(int w, logic [63:0] p, logic [63:0] g, logic cin);
        exp_t e;
        logic cy, cz;
        e.c  = '0;
        e.gp = 1'b1;
        cy   = cin;
        cz   = 1'b0;
        for (int i = 0; i < w; i++) begin
            e.c[i] = cy;
            cy     = g[i] | (p[i] & cy);
            cz     = g[i] | (p[i] & cz);
            e.gp   = e.gp & p[i];
        end
        e.cout = cy;
        e.gg   = cz;
        e.v    = e.c[w-1] ^ cy;
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic rand_in();
        logic [63:0] a, b;
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        P   = a ^ b;
        G   = a & b;
        CIN = 1'($urandom);
    endtask

    // One clock: score any output transfer, record any input transfer, then advance.
    task automatic tick();
        exp_t e;
        #2;
        if (OUT_VALID && OUT_READY) begin
            total++;
            assert (q.size() != 0) pass_cnt++;
            else $error("FAIL sb_underflow: got output C=%h expected no output", C);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_c", C, e.c);
                chk("sb_cout", COUT, e.cout);
                chk("sb_gp", GP, e.gp);
                chk("sb_gg", GG, e.gg);
`ifdef CLA_OVERFLOW_EN
                chk("sb_v", V, e.v);
`endif
            end
        end
        if (IN_VALID && IN_READY) q.push_back(ref_model(64, P, G, CIN));
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && q.size() != 0; i++) tick();
        chk("drain_left", q.size(), 0);
        chk("drain_out_valid", OUT_VALID, 0);
    endtask

    task automatic run16(logic [15:0] p, logic [15:0] g, logic cin);
        exp_t e;
        int   n;
        e     = ref_model(16, {48'h0, p}, {48'h0, g}, cin);
        n     = 0;
        p16   = p;
        g16   = g;
        cin16 = cin;
        iv16  = 1'b1;
        chk("w16_in_ready", ir16, 1);
        @(posedge CLK);
        #1;
        iv16 = 1'b0;
        while (!ov16 && n < 8) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("w16_latency", n, 2);
        chk("w16_c", c16, e.c);
        chk("w16_cout", cout16, e.cout);
        chk("w16_gp", gp16, e.gp);
        chk("w16_gg", gg16, e.gg);
`ifdef CLA_OVERFLOW_EN
        chk("w16_v", v16, e.v);
`endif
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: time %0t reached, required finish before 100000", $time);
    end

    initial begin
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        P         = '0;
        G         = '0;
        CIN       = 1'b0;
        iv16      = 1'b0;
        p16       = '0;
        g16       = '0;
        cin16     = 1'b0;
        #1 RST = 1'b1;
        #1;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_c", C, 0);
        chk("rst_cout", COUT, 0);
        chk("rst_gp", GP, 0);
        chk("rst_gg", GG, 0);
`ifdef CLA_OVERFLOW_EN
        chk("rst_v", V, 0);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // All-propagate word with carry-in: the carry ripples through every bit.
        P        = '1;
        G        = '0;
        CIN      = 1'b1;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("ones_lat1", OUT_VALID, 0);
        tick();
        chk("ones_lat2", OUT_VALID, 0);
        tick();
        chk("ones_lat3", OUT_VALID, 1);
        chk("ones_c", C, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ones_cout", COUT, 1);
        chk("ones_gp", GP, 1);
        chk("ones_gg", GG, 0);
        tick();

        // 0x7FFF..FF + 1: carry reaches the sign bit but not beyond.
        P        = 64'h7FFF_FFFF_FFFF_FFFE;
        G        = 64'h1;
        CIN      = 1'b0;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        chk("ovf_valid", OUT_VALID, 1);
        chk("ovf_c", C, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("ovf_cout", COUT, 0);
`ifdef CLA_OVERFLOW_EN
        chk("ovf_v", V, 1);
`endif
        tick();

        for (int i = 0; i < 100; i++) begin
            rand_in();
            IN_VALID = 1'b1;
            chk("burst_in_ready", IN_READY, 1);
            chk("burst_out_valid", OUT_VALID, i >= 3);
            tick();
        end
        IN_VALID = 1'b0;
        drain();

        // Fill with the consumer stalled, then hold while new data is offered.
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            IN_VALID = 1'b1;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            rand_in();
            chk("bp_in_ready", IN_READY, 0);
            chk("bp_out_valid", OUT_VALID, 1);
            chk("bp_c_stable", C, q[0].c);
            chk("bp_cout_stable", COUT, q[0].cout);
            tick();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        #1;
        chk("bp_release_ready", IN_READY, 1);
        chk("bp_depth", q.size(), 3);
        drain();

        // Two entries in flight when reset hits; reset acts without a clock edge.
        for (int i = 0; i < 2; i++) begin
            rand_in();
            IN_VALID = 1'b1;
            tick();
        end
        IN_VALID = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("mr_out_valid", OUT_VALID, 0);
        chk("mr_in_ready", IN_READY, 1);
        chk("mr_c", C, 0);
        chk("mr_cout", COUT, 0);
        q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        rand_in();
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("mr_lat1", OUT_VALID, 0);
        tick();
        chk("mr_lat2", OUT_VALID, 0);
        tick();
        chk("mr_lat3", OUT_VALID, 1);
        drain();

        run16(16'h00F0, 16'h000F, 1'b0);
        run16(16'hFFFF, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            run16(a ^ b, a & b, 1'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
